// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
// i2c_target_regfile : I2C target with 256x8 register file and write strobe
// Revision 1.0 - initial release
// ============================================================================
module i2c_target_regfile #(
   parameter int         CLK_IN_KHZ = 50000,
   parameter logic [6:0] DEV_ADDR   = 7'h39,
   parameter int         FILTER_LEN = 3
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       I2C_scl,
   inout  wire        I2C_sda,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       addressed,
   output logic       bus_busy
);

   localparam logic [3:0] c_FLEN = 4'(FILTER_LEN);

   // Clock frequency is documentation only; it must simply be positive.
   if (CLK_IN_KHZ < 1) begin : g_clk_invalid
   end

   typedef enum logic [3:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
      S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_ACKCHK, S_WAIT_STOP
   } state_t;

   state_t      r_state, n_state;
   logic [1:0]  r_sync [2];
   logic [3:0]  r_cnt  [2];
   logic [1:0]  r_filt, r_filt_d;
   logic [3:0]  r_bitcnt, n_bitcnt;
   logic [7:0]  r_rx, n_rx, r_tx, n_tx, r_ptr, n_ptr;
   logic        r_oe, n_oe, r_addressed, n_addressed, r_busy, n_busy;
   logic        r_strobe, n_strobe;
   logic [7:0]  r_waddr, n_waddr, r_wdata, n_wdata;
   logic [7:0]  r_mem [256];
   logic [7:0]  w_mem_rd;
   logic [1:0]  w_raw;
   logic        w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_we, w_rx_bit;

   assign w_raw    = {I2C_sda, I2C_scl};
   assign w_scl    = r_filt[0];
   assign w_sda    = r_filt[1];
   assign w_rise   = w_scl & ~r_filt_d[0];
   assign w_fall   = ~w_scl & r_filt_d[0];
   assign w_start  = w_scl & r_filt_d[0] & r_filt_d[1] & ~w_sda;
   assign w_stop   = w_scl & r_filt_d[0] & ~r_filt_d[1] & w_sda;
   assign w_mem_rd = r_mem[r_ptr];
   assign w_rx_bit = w_rise && (r_bitcnt != 4'd8) &&
                     (r_state == S_ADDR || r_state == S_REG || r_state == S_WDATA);

   assign I2C_sda   = r_oe ? 1'b0 : 1'bz;
   assign wr_strobe = r_strobe;
   assign wr_addr   = r_waddr;
   assign wr_data   = r_wdata;
   assign addressed = r_addressed;
   assign bus_busy  = r_busy;

   // Filtered line follows the synchronizer only after FILTER_LEN differing samples.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 2; i++) begin
            r_sync[i] <= 2'b11;
            r_cnt[i]  <= 4'd0;
         end
         r_filt   <= 2'b11;
         r_filt_d <= 2'b11;
      end else begin
         r_filt_d <= r_filt;
         for (int i = 0; i < 2; i++) begin
            r_sync[i] <= {r_sync[i][0], w_raw[i]};
            if (r_sync[i][1] == r_filt[i]) begin
               r_cnt[i] <= 4'd0;
            end else if (r_cnt[i] == c_FLEN - 4'd1) begin
               r_filt[i] <= r_sync[i][1];
               r_cnt[i]  <= 4'd0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= 4'd0;
         r_rx        <= 8'h00;
         r_tx        <= 8'h00;
         r_ptr       <= 8'h00;
         r_oe        <= 1'b0;
         r_addressed <= 1'b0;
         r_busy      <= 1'b0;
         r_strobe    <= 1'b0;
         r_waddr     <= 8'h00;
         r_wdata     <= 8'h00;
      end else begin
         r_state     <= n_state;
         r_bitcnt    <= n_bitcnt;
         r_rx        <= n_rx;
         r_tx        <= n_tx;
         r_ptr       <= n_ptr;
         r_oe        <= n_oe;
         r_addressed <= n_addressed;
         r_busy      <= n_busy;
         r_strobe    <= n_strobe;
         r_waddr     <= n_waddr;
         r_wdata     <= n_wdata;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in && w_we) begin
         r_mem[r_ptr] <= r_rx;
      end
   end

   always_comb begin
      n_state     = r_state;
      n_bitcnt    = r_bitcnt;
      n_rx        = r_rx;
      n_tx        = r_tx;
      n_ptr       = r_ptr;
      n_oe        = r_oe;
      n_addressed = r_addressed;
      n_busy      = r_busy;
      n_strobe    = 1'b0;
      n_waddr     = r_waddr;
      n_wdata     = r_wdata;
      w_we        = 1'b0;
      if (w_stop) begin
         n_state     = S_IDLE;
         n_oe        = 1'b0;
         n_addressed = 1'b0;
         n_busy      = 1'b0;
      end else if (w_start) begin
         n_state     = S_ADDR;
         n_bitcnt    = 4'd0;
         n_oe        = 1'b0;
         n_addressed = 1'b0;
         n_busy      = 1'b1;
      end else begin
         if (w_rx_bit) begin
            n_rx     = {r_rx[6:0], w_sda};
            n_bitcnt = r_bitcnt + 4'd1;
         end
         case (r_state)
            S_ADDR: if (w_fall && r_bitcnt == 4'd8) begin
               if (r_rx[7:1] == DEV_ADDR) begin
                  n_addressed = 1'b1;
                  n_oe        = 1'b1;
                  n_state     = S_ADDR_ACK;
               end else begin
                  n_oe    = 1'b0;
                  n_state = S_WAIT_STOP;
               end
            end
            S_ADDR_ACK: if (w_fall) begin
               n_bitcnt = 4'd0;
               if (r_rx[0]) begin
                  n_tx    = w_mem_rd;
                  n_oe    = ~w_mem_rd[7];
                  n_state = S_RDATA;
               end else begin
                  n_oe    = 1'b0;
                  n_state = S_REG;
               end
            end
            S_REG: if (w_fall && r_bitcnt == 4'd8) begin
               n_ptr   = r_rx;
               n_oe    = 1'b1;
               n_state = S_REG_ACK;
            end
            S_WDATA: if (w_fall && r_bitcnt == 4'd8) begin
               w_we     = 1'b1;
               n_strobe = 1'b1;
               n_waddr  = r_ptr;
               n_wdata  = r_rx;
               n_ptr    = r_ptr + 8'd1;
               n_oe     = 1'b1;
               n_state  = S_WDATA_ACK;
            end
            S_REG_ACK, S_WDATA_ACK: if (w_fall) begin
               n_oe     = 1'b0;
               n_bitcnt = 4'd0;
               n_state  = S_WDATA;
            end
            S_RDATA: begin
               if (w_rise && r_bitcnt != 4'd8) begin
                  n_bitcnt = r_bitcnt + 4'd1;
               end else if (w_fall && r_bitcnt == 4'd8) begin
                  n_oe     = 1'b0;
                  n_ptr    = r_ptr + 8'd1;
                  n_bitcnt = 4'd0;
                  n_state  = S_RD_ACKCHK;
               end else if (w_fall) begin
                  n_tx = {r_tx[6:0], r_tx[7]};
                  n_oe = ~r_tx[6];
               end
            end
            // bitcnt==1 marks a master ACK seen; the next byte starts on the fall.
            S_RD_ACKCHK: begin
               if (w_rise) begin
                  if (!w_sda) n_bitcnt = 4'd1;
                  else        n_state  = S_WAIT_STOP;
               end else if (w_fall && r_bitcnt == 4'd1) begin
                  n_tx     = w_mem_rd;
                  n_oe     = ~w_mem_rd[7];
                  n_bitcnt = 4'd0;
                  n_state  = S_RDATA;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter CLK_IN_KHZ, default 50000, source clock frequency in KHz; informational only, no logic depends on it.
REQ-002 SHALL have parameter DEV_ADDR, default 7'h39, 7-bit target address (write byte 0x72, read byte 0x73).
REQ-003 SHALL have parameter FILTER_LEN, default 3, number of consecutive equal samples required to accept a change on SCL/SDA (range 1..15).
REQ-004 SHALL have port clk_in, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in, input, 1, synchronous active-low reset.
REQ-006 SHALL have port I2C_scl, input, 1, bus clock; the target never stretches SCL.
REQ-007 SHALL have port I2C_sda, inout, 1, open-drain data; driven 1'b0 or high-Z only.
REQ-008 SHALL have port wr_strobe, output, 1, one-cycle pulse per register byte written.
REQ-009 SHALL have port wr_addr, output, 8, register address of the current write.
REQ-010 SHALL have port wr_data, output, 8, data of the current write.
REQ-011 SHALL have port addressed, output, 1, high while selected (address matched) until STOP or START.
REQ-012 SHALL have port bus_busy, output, 1, high from START to STOP.

Function
REQ-013 SHALL synchronize SCL and SDA with 2 flops each, then filter: filtered value updates only after FILTER_LEN consecutive identical synchronized samples.
REQ-014 SHALL detect START as filtered SDA 1->0 while filtered SCL high; STOP as SDA 0->1 while SCL high; neither is treated as a data bit.
REQ-015 SHALL sample data bits MSB first on the SCL rising edge and change its SDA drive only on the SCL falling edge.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_ACKCHK, WAIT_STOP.
REQ-017 SHALL go to ADDR and clear the bit counter on START or repeated START from any state.
REQ-018 SHALL go to IDLE, release SDA, and drop addressed on STOP from any state.
REQ-019 ADDR: after 8 bits, if bits[7:1]==DEV_ADDR, assert addressed and go ADDR_ACK; else go WAIT_STOP with SDA released (no ACK).
REQ-020 ACK phases: pull SDA low from the SCL falling edge after bit 8 until the next SCL falling edge, then release.
REQ-021 After ADDR_ACK: R/W=0 -> REG; R/W=1 -> RDATA, loading shift register from regfile[ptr].
REQ-022 REG: the 8 received bits load ptr; ACK; then WDATA.
REQ-023 WDATA: the SCL falling edge after bit 8 writes regfile[ptr], pulses wr_strobe for exactly 1 clk_in with wr_addr=ptr and wr_data=byte, increments ptr, ACKs, and returns to WDATA.
REQ-024 RDATA: drive SDA low for 0 bits, high-Z for 1 bits; after bit 8 release SDA and go RD_ACKCHK, incrementing ptr.
REQ-025 RD_ACKCHK: master ACK (SDA 0 at SCL rise) -> load regfile[ptr], RDATA; NACK -> WAIT_STOP.
REQ-026 ptr SHALL be 8 bits and wrap 0xFF->0x00 on increment.
REQ-027 The register file SHALL be 256x8, not cleared by reset, written only via REQ-023.
REQ-028 bus_busy SHALL set on START and clear on STOP, independent of address match.
REQ-029 A filtered pulse shorter than FILTER_LEN samples SHALL cause no state change.

Reset
REQ-030 While rst_in=0: state IDLE, SDA high-Z, ptr=0x00, wr_strobe=0, wr_addr=0x00, wr_data=0x00, addressed=0, bus_busy=0, filters and synchronizers preset to 1.
REQ-031 Reset asserted mid-transfer SHALL abort immediately; after release the target ignores the bus until the next START.

Verification
REQ-032 START, 0x72, 0x98, 0x03, STOP at 100 KHz, clk_in 50 MHz -> 3 ACKs, one wr_strobe with wr_addr=0x98, wr_data=0x03; SDA released after STOP.
REQ-033 START, 0x74, 0x00, STOP -> no ACK on any byte, no wr_strobe, addressed stays 0, bus_busy high between START and STOP.
REQ-034 Write 0x98<-0x03; then START, 0x72, 0x98, repeated START, 0x73, read one byte, master NACK, STOP -> target drives 0x03.
REQ-035 START, 0x72, 0xFF, 0xAA, 0x55, STOP -> strobes (0xFF,0xAA) then (0x00,0x55); subsequent read from 0xFF returns 0xAA then 0x55.
REQ-036 Two-cycle SDA low glitch while SCL high (FILTER_LEN=3) -> no START detected, bus_busy stays 0.
REQ-037 rst_in low during bit 4 of a data byte -> SDA high-Z next cycle, no wr_strobe; the next full transaction completes normally.
